// File: rtl/gnn_relu_sched_if.sv
// Bundle of run-control, feature-buffer, ReLU-array and output-buffer signals
// between gnn_relu_sched (slave modport) and its environment (master modport).
interface gnn_relu_sched_if #(
    parameter int AW = 6
);
    // Handshakes: start is a request sampled only while busy=0; relu_in_ready is a
    // one-cycle fire answered by relu_ready_out; a write transfers in the cycle
    // wr_en=1, and wr_en is never raised while wr_stall=1.
    logic          start;
    logic [AW:0]   num_groups;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          relu_in_ready;
    logic          relu_ready_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_stall;
    logic [2:0]    fsm_state;

    modport slave (
        input  start, num_groups, relu_ready_out, wr_stall,
        output busy, done, err, rd_en, rd_addr, relu_in_ready, wr_en, wr_addr,
        output fsm_state
    );

    modport master (
        output start, num_groups, relu_ready_out, wr_stall,
        input  busy, done, err, rd_en, rd_addr, relu_in_ready, wr_en, wr_addr,
        input  fsm_state
    );
endinterface

// File: rtl/gnn_relu_sched.sv
// Group sequencer for the 4x4 ReLU array: read group, fire, wait, write, repeat.
// Optional WAIT_RELU watchdog enabled by defining GNN_RELU_SCHED_TIMEOUT_EN.
module gnn_relu_sched #(
    parameter int AW      = 6,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    gnn_relu_sched_if.slave bus
);
    localparam int RW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if (RD_LAT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("gnn_relu_sched: RD_LAT and TIMEOUT must both be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_RD   = 3'd2,
        FIRE      = 3'd3,
        WAIT_RELU = 3'd4,
        WRITE     = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [AW:0]   cnt;
    logic [AW-1:0] grp, grp_n;
    logic [RW-1:0] rd_cnt;
    logic          wr_pend;
    logic          accept;
    logic          last_grp;
    logic          wr_go;
    logic          to_hit;

    assign accept    = (state == IDLE) && bus.start;
    assign last_grp  = ({1'b0, grp} == (cnt - 1'b1));
    assign wr_go     = (state == WRITE) && !bus.wr_stall;
    assign bus.fsm_state = state;
    // The write strobe is the registered WRITE flag qualified by the live stall,
    // so a stalled cycle never strobes the output buffer.
    assign bus.wr_en = wr_pend && !bus.wr_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        grp_n   = grp;
        case (state)
            IDLE: begin
                if (bus.start && (bus.num_groups != '0)) begin
                    state_n = READ;
                end
            end
            READ:      state_n = WAIT_RD;
            WAIT_RD: begin
                if (rd_cnt == '0) begin
                    state_n = FIRE;
                end
            end
            FIRE:      state_n = WAIT_RELU;
            WAIT_RELU: begin
                if (bus.relu_ready_out) begin
                    state_n = WRITE;
                end else if (to_hit) begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (!bus.wr_stall) begin
                    state_n = last_grp ? IDLE : READ;
                end
            end
            default:   state_n = IDLE;
        endcase
        if (accept) begin
            grp_n = '0;
        end else if (wr_go && !last_grp) begin
            grp_n = grp + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt               <= '0;
            grp               <= '0;
            rd_cnt            <= '0;
            wr_pend           <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.rd_en         <= 1'b0;
            bus.rd_addr       <= '0;
            bus.relu_in_ready <= 1'b0;
            bus.wr_addr       <= '0;
        end else begin
            if (accept && (bus.num_groups != '0)) begin
                cnt <= bus.num_groups;
            end
            grp <= grp_n;
            if (state == READ) begin
                rd_cnt <= RW'(RD_LAT - 1);
            end else if ((state == WAIT_RD) && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            wr_pend           <= (state_n == WRITE);
            bus.busy          <= (state_n != IDLE);
            bus.done          <= (wr_go && last_grp) || (accept && (bus.num_groups == '0));
            bus.rd_en         <= (state_n == READ);
            bus.relu_in_ready <= (state_n == FIRE);
            if (state_n == READ) begin
                bus.rd_addr <= grp_n;
            end
            if (state_n == WRITE) begin
                bus.wr_addr <= grp_n;
            end
        end
    end

`ifdef GNN_RELU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // to_cnt holds the number of WAIT_RELU cycles already spent without an answer.
    assign to_hit  = (state == WAIT_RELU) && !bus.relu_ready_out && (to_cnt == TW'(TIMEOUT - 1));
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_RELU) ? to_cnt + 1'b1 : '0;
            if (accept) begin
                err_q <= 1'b0;
            end else if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_gnn_relu_sched.sv
// Directed bench for gnn_relu_sched: read/write address scoreboard, cycle-accurate
// done timing, backpressure, ignored restart, mid-run reset and timeout handling.
module tb_gnn_relu_sched;
    localparam int AW      = 6;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gnn_relu_sched_if #(.AW(AW)) bus ();

    gnn_relu_sched #(.AW(AW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int rel;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] rd_q[$];

    int rd_seen, wr_seen, fire_cnt, busy_cnt, busy_first, done_cnt, stall_viol, lat_sum;
    int relu_lat  = 1;
    bit rand_lat  = 1'b0;
    bit relu_mute = 1'b0;

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_seen = 0; wr_seen = 0; fire_cnt = 0; busy_cnt = 0; busy_first = -1;
        done_cnt = 0; stall_viol = 0; lat_sum = 0;
    endtask

    task automatic start_run(input int n);
        clear_stats();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(AW'(i));
            rd_q.push_back(AW'(i));
        end
        bus.num_groups = (AW + 1)'(n);
        bus.start      = 1'b1;
        t0             = cyc;
        tick(1);
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int rel_cyc);
        bit seen = 1'b0;
        rel_cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen    = 1'b1;
                rel_cyc = cyc - t0;
                check("busy_at_done", bus.busy, 0);
            end
        end
        check("done_seen", seen, 1);
        #1;
    endtask

    task automatic wait_fire(input int k, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (fire_cnt >= k) seen = 1'b1;
        end
        check("fire_seen", seen, 1);
    endtask

    // ReLU array model: answers relu_lat cycles after each fire
    initial begin
        int lat;
        bus.relu_ready_out = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.relu_in_ready && !relu_mute) begin
                lat = rand_lat ? int'($urandom_range(1, 7)) : relu_lat;
                lat_sum += lat;
                repeat (lat) @(posedge clk);
                #1 bus.relu_ready_out = 1'b1;
                @(posedge clk);
                #1 bus.relu_ready_out = 1'b0;
            end
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_seen++;
                check("rd_q_avail", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) check("rd_addr", bus.rd_addr, rd_q.pop_front());
            end
            if (bus.wr_en) begin
                wr_seen++;
                check("wr_q_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("wr_addr", bus.wr_addr, exp_q.pop_front());
            end
            if (bus.wr_en && bus.wr_stall) stall_viol++;
            if (bus.relu_in_ready) fire_cnt++;
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
            end
            if (bus.done) done_cnt++;
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.num_groups = '0;
        bus.wr_stall   = 1'b0;
        clear_stats();
        rst = 1'b1;
        tick(2);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_relu_in_ready", bus.relu_in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        rst = 1'b0;
        tick(2);

        // basic run: 3 groups, 1-cycle ReLU
        relu_lat = 1;
        start_run(3);
        wait_done(100, rel);
        check("basic_done_cycle", rel, 16);
        tick(1);
        check("basic_fires", fire_cnt, 3);
        check("basic_busy_cycles", busy_cnt, 15);
        check("basic_busy_first", busy_first - t0, 1);
        check("basic_reads", rd_seen, 3);
        check("basic_writes", wr_seen, 3);
        check("basic_done_count", done_cnt, 1);
        check("basic_q_empty", exp_q.size() + rd_q.size(), 0);

        // zero length, then a new start in the done cycle
        tick(2);
        start_run(0);
        wait_done(10, rel);
        check("zero_done_cycle", rel, 1);
        check("zero_busy", busy_cnt, 0);
        check("zero_rd_wr", rd_seen + wr_seen, 0);
        start_run(1);
        wait_done(50, rel);
        check("b2b_done_cycle", rel, 6);
        check("b2b_writes", wr_seen, 1);

        // backpressure: 4 stalled cycles on the group-1 write
        tick(2);
        start_run(3);
        tick(9);
        bus.wr_stall = 1'b1;
        tick(4);
        bus.wr_stall = 1'b0;
        wait_done(100, rel);
        check("stall_done_cycle", rel, 20);
        check("stall_wr_en_low", stall_viol, 0);
        check("stall_writes", wr_seen, 3);
        check("stall_q_empty", exp_q.size(), 0);

        // start mid-run with another count is ignored
        tick(2);
        start_run(2);
        tick(2);
        bus.num_groups = (AW + 1)'(5);
        bus.start      = 1'b1;
        tick(1);
        bus.start      = 1'b0;
        wait_done(100, rel);
        check("restart_done_cycle", rel, 11);
        check("restart_writes", wr_seen, 2);
        check("restart_q_empty", exp_q.size(), 0);

        // variable ReLU latency 1..7
        tick(2);
        rand_lat = 1'b1;
        start_run(6);
        wait_done(400, rel);
        check("varlat_done_cycle", rel, 4 * 6 + lat_sum + 1);
        check("varlat_fires", fire_cnt, 6);
        check("varlat_writes", wr_seen, 6);
        check("varlat_q_empty", exp_q.size(), 0);
        rand_lat = 1'b0;

        // reset during group-2 WAIT_RELU
        tick(2);
        relu_lat = 5;
        start_run(4);
        wait_fire(3, 200);
        tick(1);
        check("pre_rst_state", bus.fsm_state, 4);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {bus.busy, bus.done, bus.err, bus.rd_en, bus.rd_addr,
                                 bus.relu_in_ready, bus.wr_en, bus.wr_addr}, 0);
        check("midrst_state", bus.fsm_state, 0);
        tick(2);
        rst = 1'b0;
        check("midrst_writes", wr_seen, 2);
        exp_q.delete();
        rd_q.delete();
        tick(10);
        check("midrst_no_done", done_cnt, 0);
        relu_lat = 1;
        start_run(2);
        wait_done(100, rel);
        check("postrst_done_cycle", rel, 11);
        check("postrst_writes", wr_seen, 2);

`ifdef GNN_RELU_SCHED_TIMEOUT_EN
        // ReLU never answers: error after TIMEOUT WAIT_RELU cycles
        tick(2);
        relu_mute = 1'b1;
        start_run(2);
        tick(10);
        check("to_still_waiting", bus.fsm_state, 4);
        check("to_err_early", bus.err, 0);
        tick(1);
        check("to_err_set", bus.err, 1);
        check("to_busy", bus.busy, 0);
        check("to_idle", bus.fsm_state, 0);
        tick(5);
        check("to_no_done", done_cnt, 0);
        check("to_err_sticky", bus.err, 1);
        exp_q.delete();
        rd_q.delete();
        relu_mute = 1'b0;
        start_run(1);
        check("to_err_cleared", bus.err, 0);
        wait_done(50, rel);
        check("to_next_done_cycle", rel, 6);
`else
        // ReLU never answers: the sequencer waits indefinitely without error
        tick(2);
        relu_mute = 1'b1;
        start_run(1);
        tick(30);
        check("hang_state", bus.fsm_state, 4);
        check("hang_err", bus.err, 0);
        check("hang_busy", bus.busy, 1);
        check("hang_no_done", done_cnt, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        rd_q.delete();
        relu_mute = 1'b0;
        tick(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
